// File: rtl/lm_sm_sequencer.sv
// LM/SM multi-register transfer sequencer.
// Walks an 8-bit register list lowest index first and moves one register per
// two-cycle slot between the register file and consecutive memory addresses.
module lm_sm_sequencer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREG   = 8
) (
   input  logic              clk,
   input  logic              proc_rst,
   input  logic              start,
   input  logic              is_store,
   input  logic [NREG-1:0]   reg_list,
   input  logic [DATA_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [2:0]        rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [2:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              rf_wen
);

   typedef enum logic [1:0] {S_IDLE, S_PH1, S_PH2, S_FIN} state_e;

   state_e              state_q, state_d;
   logic [NREG-1:0]     pend_q, pend_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic                store_q, store_d;
   logic [2:0]          idx_q, idx_d;

   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [2:0]          rf_raddr_q, rf_raddr_d;
   logic [2:0]          rf_waddr_q, rf_waddr_d;
   logic                rf_wen_q, rf_wen_d;

   // Index of the lowest set bit; scanning downward lets the lowest one win.
   function automatic logic [2:0] lowest_set(input logic [NREG-1:0] v);
      logic [2:0] r;
      r = '0;
      for (int unsigned k = NREG; k > 0; k--) begin
         if (v[k-1]) r = 3'(k - 1);
      end
      return r;
   endfunction

   // State, transfer context and registered outputs.
   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         state_q     <= S_IDLE;
         pend_q      <= '0;
         addr_q      <= '0;
         store_q     <= 1'b0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_wdata_q <= '0;
         rf_raddr_q  <= '0;
         rf_waddr_q  <= '0;
         rf_wen_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         addr_q      <= addr_d;
         store_q     <= store_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mem_addr_q  <= mem_addr_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_wdata_q <= mem_wdata_d;
         rf_raddr_q  <= rf_raddr_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wen_q    <= rf_wen_d;
      end
   end

   // Next state plus the pending list, address and direction bookkeeping.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      addr_d  = addr_q;
      store_d = store_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               pend_d  = reg_list;
               addr_d  = base_addr;
               store_d = is_store;
               state_d = (reg_list != '0) ? S_PH1 : S_FIN;
            end
         end
         S_PH1: state_d = S_PH2;
         S_PH2: begin
            pend_d  = pend_q & ~(NREG'(1) << idx_q);
            addr_d  = addr_q + DATA_W'(1);
            state_d = (pend_d != '0) ? S_PH1 : S_FIN;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      idx_d = (state_d == S_PH1) ? lowest_set(pend_d) : idx_q;
   end

   // Outputs for the state being entered, so they appear registered in it.
   always_comb begin
      busy_d      = (state_d != S_IDLE);
      done_d      = 1'b0;
      mem_addr_d  = '0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_wdata_d = '0;
      rf_raddr_d  = '0;
      rf_waddr_d  = '0;
      rf_wen_d    = 1'b0;
      unique case (state_d)
         S_PH1: begin
            if (store_d) begin
               rf_raddr_d = idx_d;
            end else begin
               mem_read_d = 1'b1;
               mem_addr_d = addr_d;
            end
         end
         S_PH2: begin
            if (store_q) begin
               mem_write_d = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = rf_rdata;
            end else begin
               rf_wen_d   = 1'b1;
               rf_waddr_d = idx_q;
            end
         end
         S_FIN:   done_d = 1'b1;
         default: ;
      endcase
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_addr  = mem_addr_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_wdata = mem_wdata_q;
   assign rf_raddr  = rf_raddr_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wen    = rf_wen_q;
   // Load data only becomes valid during PH2 itself, so it is forwarded
   // straight through, gated by the registered write enable.
   assign rf_wdata  = rf_wen_q ? mem_rdata : '0;

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
Multi-register transfer engine for the multicycle core's LM (opcode 6) and SM (opcode 7) instructions.
- The main controller hands over the 8-bit register list, base address and direction, then waits for done.
- The block walks the list lowest-index first, moving one register per 2-cycle slot between the register file and memory at consecutive addresses.
- It replaces the inline priority-encoder/state 30–37 loop with a self-contained start/done block.

Parameters:
DATA_W, 16, data and address width
NREG, 8, register-file entries and register-list width (register index width is fixed at 3)

Ports:
clk  in  1  system clock; all state updates on rising edge
proc_rst  in  1  reset
start  in  1  one-cycle request from main controller; sampled only in IDLE
is_store  in  1  1 = SM (RF to mem), 0 = LM (mem to RF); latched at start
reg_list  in  NREG  bit i set = transfer register Ri; latched at start
base_addr  in  DATA_W  address of first transfer; latched at start
busy  out  1  high from the cycle after start is accepted through the done cycle
done  out  1  one-cycle pulse on completion
mem_addr  out  DATA_W  memory address
mem_read  out  1  memory read strobe; rdata is valid the following cycle
mem_write  out  1  memory write strobe
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data; valid one cycle after mem_read
rf_raddr  out  3  register-file read address; rf_rdata returns combinationally
rf_rdata  in  DATA_W  register-file read data
rf_waddr  out  3  register-file write address
rf_wdata  out  DATA_W  register-file write data
rf_wen  out  1  register-file write enable

Behaviour:
Interface (already decided): one clock; reset is asynchronous and active-low (proc_rst, active-low async).

Reset:
- proc_rst=0 forces state IDLE and clears every output (busy, done, mem_read, mem_write, rf_wen = 0; all address/data outputs = 0), the internal list, address and index registers.
- Asserting reset mid-transfer aborts immediately. No further strobes are issued and no done pulse is produced.

State and output rules:
- States: IDLE, PH1, PH2, FIN. All outputs are registered.
- IDLE: start=1 latches reg_list into pend, base_addr into addr, and is_store. Next state is PH1 if pend≠0, otherwise FIN. start is ignored in every other state.
- PH1: select i = index of the lowest set bit of pend.
  - Load: mem_read=1, mem_addr=addr.
  - Store: rf_raddr=i.
  - Next state PH2.
- PH2:
  - Load: rf_wen=1, rf_waddr=i, rf_wdata=mem_rdata.
  - Store: mem_write=1, mem_addr=addr, mem_wdata=rf_rdata captured at the end of PH1.
  - At the end of PH2, clear bit i of pend and set addr=addr+1 (modulo 2^DATA_W; 0xFFFF wraps to 0x0000).
  - Next state is PH1 if pend≠0, otherwise FIN.
- FIN: done=1 for exactly one cycle, busy stays 1. Next state IDLE, where busy=0.
- Strobes (mem_read, mem_write, rf_wen) are high for exactly one cycle each. mem_read and mem_write are never high together.

Latency:
- With n = popcount(reg_list) and start accepted at edge E0, done is high in cycle E0+2n+1.
- Empty list: done is high in cycle E0+1 with no memory or RF strobes.

Boundary cases:
- A start asserted on the same edge that FIN returns to IDLE is not accepted. A new start is accepted only in a cycle where the block is IDLE.
- Loading into R7 (PC) is performed like any other register. Priority over PC update belongs to the main controller.
- reg_list, base_addr and is_store may change after acceptance without effect on the transfer in progress.

Test Plan:
1. LM, reg_list=8'b1000_0101, base=0x0040, mem[0x40..0x42]=0x1111,0x2222,0x3333 → writes R0=0x1111, R2=0x2222, R7=0x3333 in that order; mem_read at 0x40/0x41/0x42; done at E0+7.
2. SM, reg_list=8'hFF, base=0x0100, Ri=0xA000+i → mem[0x100+i]=0xA000+i for i=0..7; 8 mem_write pulses; no rf_wen; done at E0+17.
3. Empty list (reg_list=0, either direction) → done at E0+1; zero mem_read, mem_write and rf_wen pulses; busy high for 1 cycle.
4. Wrap: SM, reg_list=8'b0000_0011, base=0xFFFF → writes at 0xFFFF (R0) then 0x0000 (R1).
5. start re-pulsed each cycle while busy during an LM of 3 registers → only one transfer; exactly 3 rf_wen pulses; single done pulse.
6. Reset mid-operation: proc_rst low after 2nd PH2 of an 8-register SM → all outputs 0 asynchronously; no done. After release, a fresh LM of 1 register completes in 3 cycles.
